shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the data width in bits (power of two, N >= 2).
REQ-002 The block SHALL have localparam W = clog2(N), giving the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid (input, 1), req0_ready (output, 1), req0_data (input, N), req0_amt (input, W) and req0_dir (input, 1; 0 = rotate right, 1 = rotate left) for requester 0.
REQ-006 The block SHALL have ports req1_valid, req1_ready, req1_data, req1_amt and req1_dir for requester 1, with the same directions, widths and meanings as requester 0.
REQ-007 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, N: rotated result) and out_id (output, 1: requester index of the result).

Function
REQ-008 A transfer on any channel SHALL occur only in a cycle where valid and ready are both 1 at the clk edge.
REQ-009 The block SHALL hold one result register with a 2-state FSM: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-010 The FSM SHALL be able to accept a request when it is in EMPTY, or when it is in FULL with out_ready = 1 (drain and refill in the same cycle), giving a throughput of 1 per cycle.
REQ-011 When the FSM can accept and exactly one reqX_valid = 1, the block SHALL assert only that reqX_ready.
REQ-012 When the FSM can accept and both valids = 1, the block SHALL assert ready only for the requester selected by the round-robin pointer prio (0 = requester 0 favoured).
REQ-013 On every accepted request from requester g, prio SHALL become the other requester; prio SHALL be unchanged when nothing is accepted.
REQ-014 The block SHALL never assert req0_ready and req1_ready in the same cycle.
REQ-015 The block SHALL never assert either reqX_ready while in FULL with out_ready = 0.
REQ-016 reqX_ready MAY depend combinationally on the valids and on out_ready; out_valid SHALL depend only on registered state.
REQ-017 For an accepted request, out_data SHALL equal data rotated by amt positions in direction dir, computed combinationally from the granted inputs and registered at acceptance.
REQ-018 out_valid SHALL assert on the cycle after acceptance, giving a latency of 1 cycle.
REQ-019 amt = 0 SHALL pass the data unchanged, and rotation SHALL wrap modulo N with no bit loss.
REQ-020 Rotate-left SHALL be implemented as bit-reverse, then rotate-right, then bit-reverse.
REQ-021 out_data, out_id and out_valid SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-022 When out_valid = 1, out_ready = 1 and no request is accepted, the FSM SHALL go to EMPTY.
REQ-023 Requesters SHALL keep valid and payload stable until ready is asserted; the block does not check this.

Reset
REQ-024 While reset = 1, the block SHALL drive out_valid = 0, out_data = 0, out_id = 0, prio = 0 and FSM = EMPTY, with no transfer accepted.
REQ-025 An assertion of reset while in FULL SHALL discard the pending result without any output handshake.
REQ-026 In the first cycle after reset deasserts, the block SHALL be able to accept a request.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (EMPTY, FULL) and the dir encodings (DIR_RIGHT = 0, DIR_LEFT = 1).
REQ-028 The datapath SHALL be in one combinational sub-module, rotate_core (parameter N; ports data, amt, dir, result), which implements REQ-019 and REQ-020.
REQ-029 The arbiter, FSM and result register SHALL remain in shift_arbiter.

Verification (N = 8)
REQ-030 The bench SHALL drive req0 {data = 8'b1000_0001, amt = 1, dir = 0} alone with out_ready = 1, and SHALL check that out_data = 8'b1100_0000 and out_id = 0 exactly 1 cycle after acceptance.
REQ-031 The bench SHALL drive req1 {data = 8'h96, amt = 3, dir = 1}, and SHALL check that out_data = 8'hB4; it SHALL then drive amt = 0, and SHALL check that out_data = 8'h96.
REQ-032 The bench SHALL hold both requesters valid for 4 cycles with out_ready = 1 after reset, and SHALL check that the grants are req0, req1, req0, req1 and that the two readies are never both high.
REQ-033 The bench SHALL hold out_ready = 0 for 3 cycles while FULL with req0 valid, and SHALL check that out_data and out_id are stable, req0_ready = 0, and that raising out_ready drains and accepts req0 in the same cycle.
REQ-034 The bench SHALL assert reset for 1 cycle while FULL, and SHALL check that out_valid = 0 the next cycle, no stale result appears, and prio = 0, so that with both requesters valid req0 is granted first.
REQ-035 The bench SHALL run a random stream of 1000 requests with random out_ready backpressure, and SHALL check the results against a reference model for ordering, rotation values and id.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared encodings for the two-requester rotate arbiter.
// Holds the FSM state and rotate direction constants.
package shift_arbiter_pkg;

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_FULL   = 1'b1;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_arbiter_rotate_core.sv
// Combinational rotator: rotate right directly, rotate left
// by mirroring the word around a rotate-right.
module rotate_core
    import shift_arbiter_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] data,
    input  logic [W-1:0] amt,
    input  logic         dir,
    output logic [N-1:0] result
);

    logic [N-1:0]   rev_in;
    logic [N-1:0]   src;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rr;
    logic [N-1:0]   rev_out;

    for (genvar i = 0; i < N; i++) begin : g_rev
        assign rev_in[i]  = data[N-1-i];
        assign rev_out[i] = rr[N-1-i];
    end

    // Doubling the word makes the right shift wrap with no bit loss.
    always_comb begin
        src    = (dir == DIR_LEFT) ? rev_in : data;
        dbl    = {src, src} >> amt;
        rr     = dbl[N-1:0];
        result = (dir == DIR_LEFT) ? rev_out : rr;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter between two rotate requesters feeding a
// single registered result slot with valid/ready handshakes.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_data,
    input  logic [W-1:0] req0_amt,
    input  logic         req0_dir,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_data,
    input  logic [W-1:0] req1_amt,
    input  logic         req1_dir,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_id
);

    logic [0:0]   state;
    logic         prio;
    logic         can_accept;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [N-1:0] sel_data;
    logic [W-1:0] sel_amt;
    logic         sel_dir;
    logic [N-1:0] rot;

    assign out_valid = (state == ST_FULL);

    // The slot can refill in the same cycle it drains.
    assign can_accept = !reset && (!out_valid || out_ready);

    assign grant0 = can_accept && req0_valid
                 && (!req1_valid || !prio);
    assign grant1 = can_accept && req1_valid
                 && (!req0_valid || prio);
    assign accept = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_data = grant1 ? req1_data : req0_data;
    assign sel_amt  = grant1 ? req1_amt  : req0_amt;
    assign sel_dir  = grant1 ? req1_dir  : req0_dir;

    rotate_core #(.N(N)) u_rot (
        .data   (sel_data),
        .amt    (sel_amt),
        .dir    (sel_dir),
        .result (rot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            prio     <= 1'b0;
            out_data <= '0;
            out_id   <= 1'b0;
        end else if (accept) begin
            state    <= ST_FULL;
            prio     <= !grant1;
            out_data <= rot;
            out_id   <= grant1;
        end else if (out_ready) begin
            state    <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and random checks of shift_arbiter at N = 8
// against hand-computed values and a reference queue.
module tb_shift_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid, req0_ready, req0_dir;
    logic [7:0] req0_data;
    logic [2:0] req0_amt;
    logic       req1_valid, req1_ready, req1_dir;
    logic [7:0] req1_data;
    logic [2:0] req1_amt;
    logic       out_valid, out_ready, out_id;
    logic [7:0] out_data;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    shift_arbiter #(.N(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    function automatic logic [7:0] ref_rot(logic [7:0] d,
                                           logic [2:0] a,
                                           logic l);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (l) r[(i + int'(a)) % 8] = d[i];
            else   r[i] = d[(i + int'(a)) % 8];
        end
        return r;
    endfunction

    logic [8:0] q[$];
    logic [8:0] exp_o;
    logic       mprio, ev, can, e0, e1, g0, g1;
    int         accepted, cycles;

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_data = 0; req0_amt = 0; req0_dir = 0;
        req1_valid = 0; req1_data = 0; req1_amt = 0; req1_dir = 0;
        out_ready = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_id", out_id, 0);
        @(negedge clk);
        reset = 1'b0;

        // single req0, rotate right
        req0_valid = 1; req0_data = 8'b1000_0001;
        req0_amt = 1; req0_dir = 0; out_ready = 1;
        #1;
        check("t1_rdy", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 8'b1100_0000);
        check("t1_id", out_id, 0);

        // req1 rotate left, then amt 0 back-to-back
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_data = 8'h96;
        req1_amt = 3; req1_dir = 1;
        #1;
        check("t2_rdy", {req1_ready, req0_ready}, 2'b10);
        @(posedge clk); #1;
        check("t2_data", out_data, 8'hB4);
        check("t2_id", out_id, 1);
        @(negedge clk);
        req1_amt = 0;
        #1;
        check("t2_refill", req1_ready, 1);
        @(posedge clk); #1;
        check("t2_amt0", out_data, 8'h96);
        check("t2_id0", out_id, 1);
        @(negedge clk);
        req1_valid = 0;
        @(posedge clk); #1;
        check("t2_drain", out_valid, 0);

        // round-robin with both valid
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        req0_valid = 1; req0_data = 8'h01;
        req0_amt = 1; req0_dir = 1;
        req1_valid = 1; req1_data = 8'h80;
        req1_amt = 1; req1_dir = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_grant", {req1_ready, req0_ready},
                  (i % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_both", req0_ready & req1_ready, 0);
            @(posedge clk); #1;
            check("rr_id", out_id, i % 2);
            check("rr_data", out_data,
                  (i % 2 == 0) ? 8'h02 : 8'h40);
            @(negedge clk);
        end

        // backpressure while full
        req1_valid = 0;
        out_ready = 0;
        req0_data = 8'h3C; req0_amt = 2; req0_dir = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy", req0_ready, 0);
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 8'h40);
            check("bp_id", out_id, 1);
            @(negedge clk);
        end
        out_ready = 1;
        #1;
        check("bp_release", req0_ready, 1);
        @(posedge clk); #1;
        check("bp_new_data", out_data, 8'h0F);
        check("bp_new_id", out_id, 0);
        check("bp_new_valid", out_valid, 1);

        // reset while full
        @(negedge clk);
        out_ready = 0; reset = 1;
        req0_data = 8'hA5; req0_amt = 1; req0_dir = 1;
        req1_valid = 1; req1_data = 8'h11;
        req1_amt = 2; req1_dir = 0;
        #1;
        check("rf_rdy", {req1_ready, req0_ready}, 2'b00);
        @(posedge clk); #1;
        check("rf_valid", out_valid, 0);
        check("rf_data", out_data, 0);
        check("rf_id", out_id, 0);
        @(negedge clk);
        reset = 0; out_ready = 1;
        #1;
        check("rf_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        check("rf_out_id", out_id, 0);
        check("rf_out_data", out_data, 8'h4B);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;

        // random stream against reference queue
        reset = 1;
        @(negedge clk);
        reset = 0;
        mprio = 0;
        accepted = 0;
        cycles = 0;
        while (accepted < 1000 && cycles < 20000) begin
            if (!req0_valid && $urandom_range(0, 3) != 0) begin
                req0_valid = 1;
                req0_data = 8'($urandom);
                req0_amt = 3'($urandom_range(0, 7));
                req0_dir = 1'($urandom_range(0, 1));
            end
            if (!req1_valid && $urandom_range(0, 3) != 0) begin
                req1_valid = 1;
                req1_data = 8'($urandom);
                req1_amt = 3'($urandom_range(0, 7));
                req1_dir = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            ev = (q.size() != 0);
            check("rnd_valid", out_valid, ev);
            can = !ev || out_ready;
            e0 = can && req0_valid && (!req1_valid || !mprio);
            e1 = can && req1_valid && (!req0_valid || mprio);
            check("rnd_grant", {req1_ready, req0_ready}, {e1, e0});
            if (ev && out_ready) begin
                exp_o = q.pop_front();
                check("rnd_out", {out_id, out_data}, exp_o);
            end
            g0 = req0_ready;
            g1 = req1_ready;
            if (g0) begin
                q.push_back({1'b0,
                    ref_rot(req0_data, req0_amt, req0_dir)});
                mprio = 1;
                accepted++;
            end
            if (g1) begin
                q.push_back({1'b1,
                    ref_rot(req1_data, req1_amt, req1_dir)});
                mprio = 0;
                accepted++;
            end
            @(posedge clk);
            @(negedge clk);
            if (g0) req0_valid = 0;
            if (g1) req1_valid = 0;
            cycles++;
        end
        if (accepted < 1000) check("rnd_timeout", accepted, 1000);

        req0_valid = 0; req1_valid = 0; out_ready = 1;
        #1;
        if (q.size() != 0) begin
            check("rnd_last_valid", out_valid, 1);
            exp_o = q.pop_front();
            check("rnd_last", {out_id, out_data}, exp_o);
        end
        @(posedge clk); #1;
        check("rnd_drain", out_valid, 0);
        check("rnd_q", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
